// File: rtl/sig_xy_stream_if.sv
// Stream bundle for sig_xy_stream: pixel input, Gaussian side channel, result output.
// The slave view is the block itself; master is the surrounding system.
interface sig_xy_stream_if #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int PIXEL_WIDTH     = 8
);
    localparam int IW = PIXELS_PER_BEAT * PIXEL_WIDTH;
    localparam int GW = PIXELS_PER_BEAT * 2 * PIXEL_WIDTH;
    localparam int OW = PIXELS_PER_BEAT * (2 * PIXEL_WIDTH + 1);

    logic [IW-1:0] in_x;
    logic [IW-1:0] in_y;
    logic          in_valid;
    logic          in_ready;

    logic [GW-1:0] gauss_in_data;
    logic          gauss_in_valid;

    logic [GW-1:0] gauss_out_data;
    logic          gauss_out_valid;
    logic          gauss_out_ready;

    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic          err_underflow;

    modport slave (
        input  in_x,
        input  in_y,
        input  in_valid,
        output in_ready,
        output gauss_in_data,
        output gauss_in_valid,
        input  gauss_out_data,
        input  gauss_out_valid,
        output gauss_out_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last,
        output err_underflow
    );

    modport master (
        output in_x,
        output in_y,
        output in_valid,
        input  in_ready,
        input  gauss_in_data,
        input  gauss_in_valid,
        output gauss_out_data,
        output gauss_out_valid,
        input  gauss_out_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  err_underflow
    );
endinterface

// File: rtl/sig_xy_stream.sv
// Per-lane x*y products sent to an external Gaussian; the filtered return is
// aligned against a FIFO copy of the product and the signed difference is emitted.
module sig_xy_stream #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int PIXEL_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512,
    parameter int FIFO_DEPTH      = 8,
    parameter int SATURATE        = 0
) (
    input logic            clk,
    input logic            aresetn,
    sig_xy_stream_if.slave bus
);
    localparam int LANES = PIXELS_PER_BEAT;
    localparam int PW    = PIXEL_WIDTH;
    localparam int W2    = 2 * PW;
    localparam int OWL   = W2 + 1;
    localparam int GW    = LANES * W2;
    localparam int OW    = LANES * OWL;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam int BEATS = (IMAGE_DIM * IMAGE_DIM) / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_C  = BW'(BEATS - 1);

    logic          en_q;
    logic [GW-1:0] prod_q, prod_d;
    logic          pvld_q, pvld_d;
    logic [GW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [OW-1:0] odata_q, odata_d;
    logic          ovld_q, ovld_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          err_q, err_d;

    logic          in_rdy;
    logic          accept;
    logic          g_rdy;
    logic          g_fire;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          out_fire;
    logic [GW-1:0] head;
    logic [OW-1:0] res;

    // en_q keeps in_ready low until the first edge out of reset
    assign in_rdy     = en_q & (occ_q < DEPTH_C);
    assign accept     = bus.in_valid & in_rdy;
    assign g_rdy      = ~ovld_q | bus.out_ready;
    assign g_fire     = bus.gauss_out_valid & g_rdy;
    assign fifo_empty = (fcnt_q == '0);
    assign push       = pvld_q;
    assign pop        = g_fire & ~fifo_empty;
    assign out_fire   = ovld_q & bus.out_ready;
    assign head       = mem_q[rptr_q];

    always_comb begin
        prod_d = prod_q;
        pvld_d = accept;
        if (accept) begin
            for (int j = 0; j < LANES; j++) begin
                prod_d[j*W2 +: W2] = W2'(bus.in_x[j*PW +: PW])
                                   * W2'(bus.in_y[j*PW +: PW]);
            end
        end
    end

    always_comb begin
        res = '0;
        for (int j = 0; j < LANES; j++) begin
            res[j*OWL +: OWL] = {1'b0, bus.gauss_out_data[j*W2 +: W2]}
                              - {1'b0, head[j*W2 +: W2]};
            if ((SATURATE != 0) && res[j*OWL + OWL - 1]) begin
                res[j*OWL +: OWL] = '0;
            end
        end
    end

    // occ counts the product register too; fcnt counts only stored entries
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fcnt_d = fcnt_q;
        occ_d  = occ_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        odata_d = odata_q;
        ovld_d  = ovld_q;
        beat_d  = beat_q;
        err_d   = err_q | (g_fire & fifo_empty);
        if (pop) begin
            odata_d = res;
            ovld_d  = 1'b1;
        end else if (out_fire) begin
            ovld_d  = 1'b0;
        end
        if (out_fire) begin
            beat_d = (beat_q == LAST_C) ? '0 : beat_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            en_q    <= 1'b0;
            prod_q  <= '0;
            pvld_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            occ_q   <= '0;
            odata_q <= '0;
            ovld_q  <= 1'b0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            en_q    <= 1'b1;
            prod_q  <= prod_d;
            pvld_q  <= pvld_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            occ_q   <= occ_d;
            odata_q <= odata_d;
            ovld_q  <= ovld_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= prod_q;
        end
    end

    assign bus.in_ready        = in_rdy;
    assign bus.gauss_in_data   = prod_q;
    assign bus.gauss_in_valid  = pvld_q;
    assign bus.gauss_out_ready = g_rdy;
    assign bus.out_data        = odata_q;
    assign bus.out_valid       = ovld_q;
    assign bus.out_last        = ovld_q & (beat_q == LAST_C);
    assign bus.err_underflow   = err_q;
endmodule

// File: tb/tb_sig_xy_stream.sv
// Randomised scoreboard bench for sig_xy_stream with a delay-line Gaussian model.
// Two instances (wrapping and saturating) share one stimulus stream.
module tb_sig_xy_stream;
    localparam int PPB   = 4;
    localparam int PW    = 8;
    localparam int DIM   = 8;
    localparam int DEPTH = 4;
    localparam int G     = 2;
    localparam int W2    = 2 * PW;
    localparam int OWL   = W2 + 1;
    localparam int GW    = PPB * W2;
    localparam int OW    = PPB * OWL;
    localparam int BEATS = DIM * DIM / PPB;
    localparam int GMAX  = (1 << W2) - 1;

    typedef struct packed {
        logic [OW-1:0] d0;
        logic [OW-1:0] d1;
        logic          last;
        logic          lat;
        int            t;
    } exp_t;

    typedef struct packed {
        logic [GW-1:0] g;
        int            rdy;
    } gq_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    sig_xy_stream_if #(.PIXELS_PER_BEAT(PPB), .PIXEL_WIDTH(PW)) bus ();
    sig_xy_stream_if #(.PIXELS_PER_BEAT(PPB), .PIXEL_WIDTH(PW)) bus1 ();

    assign bus1.in_x            = bus.in_x;
    assign bus1.in_y            = bus.in_y;
    assign bus1.in_valid        = bus.in_valid;
    assign bus1.gauss_out_data  = bus.gauss_out_data;
    assign bus1.gauss_out_valid = bus.gauss_out_valid;
    assign bus1.out_ready       = bus.out_ready;

    sig_xy_stream #(
        .PIXELS_PER_BEAT(PPB), .PIXEL_WIDTH(PW), .IMAGE_DIM(DIM),
        .FIFO_DEPTH(DEPTH), .SATURATE(0)
    ) dut0 (.clk(clk), .aresetn(aresetn), .bus(bus));

    sig_xy_stream #(
        .PIXELS_PER_BEAT(PPB), .PIXEL_WIDTH(PW), .IMAGE_DIM(DIM),
        .FIFO_DEPTH(DEPTH), .SATURATE(1)
    ) dut1 (.clk(clk), .aresetn(aresetn), .bus(bus1));

    exp_t                  exp_q[$];
    logic [GW-1:0]         prod_q[$];
    logic [PPB-1:0][31:0]  dl_q[$];
    gq_t                   gq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_idx = 0;
    int n_acc   = 0;
    int in_pct  = 100;
    int out_pct = 100;
    int g_pct   = 100;
    int dir     = 0;
    int cur_d   = 0;
    bit cur_force = 0;
    bit feed    = 1;
    bit g_en    = 1;
    bit mon_en  = 0;
    bit chk_gor = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int clampg(input int v);
        if (v < 0) return 0;
        if (v > GMAX) return GMAX;
        return v;
    endfunction

    task automatic accept();
        logic [GW-1:0]        p;
        logic [PPB-1:0][31:0] dv;
        exp_t                 e;
        int                   pi, gi, r, d;
        p = '0;
        e = '0;
        for (int j = 0; j < PPB; j++) begin
            pi = int'(bus.in_x[j*PW +: PW]) * int'(bus.in_y[j*PW +: PW]);
            d  = cur_force ? cur_d : int'($urandom_range(0, 6000)) - 3000;
            gi = clampg(pi + d);
            r  = gi - pi;
            p[j*W2 +: W2]   = W2'(pi);
            dv[j]           = d;
            e.d0[j*OWL +: OWL] = OWL'(r);
            e.d1[j*OWL +: OWL] = OWL'((r < 0) ? 0 : r);
        end
        e.last = ((acc_idx % BEATS) == BEATS - 1);
        e.lat  = (acc_idx == 0);
        e.t    = cyc;
        acc_idx++;
        n_acc++;
        prod_q.push_back(p);
        dl_q.push_back(dv);
        exp_q.push_back(e);
    endtask

    task automatic capture();
        gq_t                  q;
        logic [PPB-1:0][31:0] dv;
        int                   gi;
        if (dl_q.size() == 0) return;
        dv = dl_q.pop_front();
        q.g = '0;
        for (int j = 0; j < PPB; j++) begin
            gi = int'(bus.gauss_in_data[j*W2 +: W2]) + int'(dv[j]);
            q.g[j*W2 +: W2] = W2'(clampg(gi));
        end
        q.rdy = cyc + G;
        gq.push_back(q);
    endtask

    task automatic drive(input bit acc);
        if (!bus.in_valid || acc) begin
            if (feed && $urandom_range(0, 99) < in_pct) begin
                bus.in_valid = 1'b1;
                for (int j = 0; j < PPB; j++) begin
                    if (dir > 0) begin
                        bus.in_x[j*PW +: PW] = 8'd200;
                        bus.in_y[j*PW +: PW] = 8'd100;
                    end else begin
                        bus.in_x[j*PW +: PW] = 8'($urandom_range(0, 255));
                        bus.in_y[j*PW +: PW] = 8'($urandom_range(0, 255));
                    end
                end
                cur_force = (dir > 0);
                cur_d     = (dir == 2) ? 100 : -1000;
                if (dir > 0) dir--;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.out_ready = ($urandom_range(0, 99) < out_pct);
        if (g_en && gq.size() > 0 && gq[0].rdy <= cyc
            && $urandom_range(0, 99) < g_pct) begin
            bus.gauss_out_valid = 1'b1;
            bus.gauss_out_data  = gq[0].g;
        end else begin
            bus.gauss_out_valid = 1'b0;
        end
    endtask

    task automatic step();
        bit acc;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (acc) accept();
        if (bus.gauss_out_valid && bus.gauss_out_ready && gq.size() > 0)
            gq.delete(0);
        if (bus.gauss_in_valid) capture();
        @(posedge clk);
        #1;
        cyc++;
        drive(acc);
    endtask

    task automatic drain();
        int n;
        feed = 0; g_en = 1; g_pct = 100; out_pct = 100;
        n = 0;
        while ((exp_q.size() != 0 || gq.size() != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 1, 0);
    endtask

    // Scoreboard monitor
    logic [OW-1:0] pd;
    bit            pstall = 0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (pstall) begin
                chk("hold_data", bus.out_data, pd);
                chk("hold_valid", bus.out_valid, 1);
            end
            if (chk_gor && bus.out_valid)
                chk("gauss_ready_stall", bus.gauss_out_ready, 0);
            if (bus.gauss_in_valid) begin
                if (prod_q.size() == 0) chk("gauss_in_extra", 1, 0);
                else chk("gauss_in", bus.gauss_in_data, prod_q.pop_front());
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.d0);
                    chk("out_sat", bus1.out_data, e.d1);
                    chk("out_sat_valid", bus1.out_valid, 1);
                    chk("out_last", bus.out_last, e.last);
                    if (e.lat) chk("latency", cyc - e.t, G + 2);
                end
            end
            pstall = bus.out_valid && !bus.out_ready;
            pd     = bus.out_data;
        end else begin
            pstall = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.gauss_out_valid = 0;
        bus.gauss_out_data = '0;
        bus.out_ready = 0;
        aresetn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_gin_valid", bus.gauss_in_valid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_err", bus.err_underflow, 0);
        @(posedge clk);
        #1 aresetn = 1;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_rise", bus.in_ready, 1);
        mon_en = 1;

        // directed: 200*100 with +100 and -1000 Gaussian offsets, no stalls
        dir = 2; in_pct = 100; out_pct = 100; g_pct = 100;
        repeat (12) step();

        in_pct = 60; out_pct = 70; g_pct = 75;
        repeat (300) step();

        out_pct = 0; chk_gor = 1;
        repeat (5) step();
        chk_gor = 0; out_pct = 70;
        repeat (60) step();
        drain();

        // Gaussian stalled: the block must fill exactly to its depth
        g_en = 0; feed = 1; in_pct = 100; n_acc = 0;
        repeat (20) step();
        @(negedge clk);
        chk("stall_accepts", n_acc, DEPTH);
        chk("stall_in_ready", bus.in_ready, 0);
        g_en = 1; g_pct = 100; out_pct = 100;
        repeat (40) step();
        in_pct = 50; out_pct = 60; g_pct = 70;
        repeat (150) step();
        drain();
        @(negedge clk);
        chk("no_underflow", bus.err_underflow, 0);
        chk("no_underflow_sat", bus1.err_underflow, 0);

        // reset mid-frame with products outstanding, then a stale return
        g_en = 0; feed = 1; in_pct = 100;
        repeat (3) step();
        @(negedge clk);
        mon_en = 0;
        aresetn = 0;
        bus.in_valid = 0;
        bus.gauss_out_valid = 0;
        exp_q.delete(); prod_q.delete(); dl_q.delete(); gq.delete();
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 aresetn = 1;
        @(posedge clk);
        #1;
        bus.gauss_out_valid = 1;
        bus.gauss_out_data = GW'({$urandom(), $urandom()});
        bus.out_ready = 1;
        @(posedge clk);
        #1 bus.gauss_out_valid = 0;
        @(negedge clk);
        chk("underflow_err", bus.err_underflow, 1);
        chk("underflow_err_sat", bus1.err_underflow, 1);
        chk("underflow_no_out", bus.out_valid, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", bus.err_underflow, 1);
        chk("err_no_out", bus.out_valid, 0);
        aresetn = 0;
        @(negedge clk);
        chk("err_cleared_by_reset", bus.err_underflow, 0);
        @(posedge clk);
        #1 aresetn = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sig_xy_stream.md
SIG_XY_STREAM -- requirements
Module: sig_xy_stream

Interface
REQ-001 SHALL have parameter PIXELS_PER_BEAT, default 16, pixel lanes per beat.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, unsigned bits per input pixel.
REQ-003 SHALL have parameter IMAGE_DIM, default 512, square frame side in pixels.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, power of 2 ≥2, maximum outstanding products.
REQ-005 SHALL have parameter SATURATE, default 0; 1 clamps results to [0, 2^(2*PIXEL_WIDTH)-1].
REQ-006 SHALL use one clock; reset is asynchronous and active-low. Ports: clk  in  1  clock; aresetn  in  1  async active-low reset.
REQ-007 SHALL have: in_x  in  PIXELS_PER_BEAT*PIXEL_WIDTH  X pixels, lane j at bits [j*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-008 SHALL have: in_y  in  PIXELS_PER_BEAT*PIXEL_WIDTH  Y pixels, same packing.
REQ-009 SHALL have: in_valid  in  1; in_ready  out  1; input beat handshake.
REQ-010 SHALL have: gauss_in_data  out  PIXELS_PER_BEAT*2*PIXEL_WIDTH  per-lane x*y product to external Gaussian; gauss_in_valid  out  1.
REQ-011 SHALL have: gauss_out_data  in  PIXELS_PER_BEAT*2*PIXEL_WIDTH  filtered products, in issue order; gauss_out_valid  in  1; gauss_out_ready  out  1.
REQ-012 SHALL have: out_data  out  PIXELS_PER_BEAT*(2*PIXEL_WIDTH+1)  signed per-lane result; out_valid  out  1; out_ready  in  1; out_last  out  1  final beat of frame.
REQ-013 SHALL have: err_underflow  out  1  sticky; Gaussian returned a beat with no matching product.

Function
REQ-014 SHALL accept an input beat when in_valid & in_ready (cycle t).
REQ-015 SHALL register per-lane unsigned product x*y (2*PIXEL_WIDTH bits, no truncation) onto gauss_in_data with gauss_in_valid=1 at cycle t+1; gauss_in_valid=0 otherwise; external Gaussian has no backpressure.
REQ-016 SHALL push the same product into the alignment FIFO in cycle t+1.
REQ-017 SHALL keep occupancy = products issued (including the one in the product register) minus pairs popped; in_ready = (occupancy < FIFO_DEPTH).
REQ-018 SHALL drive gauss_out_ready = ~out_valid | out_ready.
REQ-019 On gauss_out_valid & gauss_out_ready with FIFO non-empty: pop head, load out_data lane j = gauss_out_data[j] - head[j] as signed 2*PIXEL_WIDTH+1 bits, set out_valid next cycle.
REQ-020 With SATURATE=1, each lane SHALL clamp negative results to 0; upper bound cannot be exceeded.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-022 out_data/out_valid/out_last SHALL hold stable while out_valid & ~out_ready.
REQ-023 out_valid SHALL clear after out_ready unless a new pair loads in the same cycle.
REQ-024 Output beat counter SHALL count delivered beats 0..IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT-1; out_last=1 on the final index; counter wraps to 0 after that beat is accepted.
REQ-025 gauss_out_valid & gauss_out_ready with FIFO empty (including same-cycle push) SHALL drop the beat, leave outputs unchanged, and set err_underflow.
REQ-026 End-to-end latency with no backpressure and a G-cycle Gaussian: out_valid G+2 cycles after input acceptance.

Reset
REQ-027 While aresetn=0: in_ready=0, gauss_in_valid=0, out_valid=0, out_last=0, out_data=0, err_underflow=0, occupancy=0, pointers=0, beat counter=0.
REQ-028 in_ready SHALL rise in the first cycle after aresetn deasserts.
REQ-029 Reset mid-frame SHALL discard all outstanding products; Gaussian returns afterwards trigger REQ-025.
REQ-030 err_underflow SHALL clear only on reset.

Verification
REQ-031 x=200,y=100 all lanes, Gaussian loopback G=2 returning 20100 -> out_data lanes = 100 at t+4.
REQ-032 Gaussian returns 19000 for product 20000, SATURATE=0 -> -1000; SATURATE=1 -> 0.
REQ-033 Gaussian stalled, continuous in_valid -> exactly FIFO_DEPTH beats accepted, in_ready=0; resume -> all results in order, no loss.
REQ-034 out_ready=0 for 5 cycles mid-stream -> out_data stable, gauss_out_ready=0, no FIFO overflow.
REQ-035 IMAGE_DIM=8, PIXELS_PER_BEAT=4, two frames -> out_last on beats 15 and 31 only.
REQ-036 Spurious gauss_out_valid after reset -> err_underflow=1, out_valid stays 0.
